// File: rtl/seg_display_scheduler_if.sv
// Bundle of requester-side handshake, digit data and display outputs for
// seg_display_scheduler; master drives requests, slave is the scheduler.
interface seg_display_scheduler_if;
  logic [2:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [2:0]  grant;
  logic [2:0]  ack;
  logic        busy;
  logic [3:0]  dig_a;
  logic [3:0]  dig_b;
  logic [3:0]  dig_c;
  logic [3:0]  dig_d;

  modport master (
    output req, data0, data1, data2,
    input  grant, ack, busy, dig_a, dig_b, dig_c, dig_d
  );

  modport slave (
    input  req, data0, data1, data2,
    output grant, ack, busy, dig_a, dig_b, dig_c, dig_d
  );
endinterface

// File: rtl/seg_display_scheduler.sv
// Round-robin sharing of a 4-digit seven-segment display between three
// requesters; each grant owns the display for HOLD_CYCLES clocks, then acks.
module seg_display_scheduler #(
  parameter int unsigned          CNT_W       = 20,
  parameter logic [CNT_W-1:0]     HOLD_CYCLES = 20'd1000000,
  parameter logic [3:0]           IDLE_CODE   = 4'hF
) (
  input  logic                    clock,
  input  logic                    reset,
  seg_display_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_CYCLES - 1'b1;
  localparam logic [15:0]      IDLE_DIGS = {4{IDLE_CODE}};

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_rr_ptr;
  logic [1:0]       r_owner;
  logic [2:0]       r_grant;
  logic [2:0]       r_ack;
  logic             r_busy;
  logic [15:0]      r_dig;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_rr_nxt;
  logic [1:0]       w_owner_nxt;
  logic [2:0]       w_grant_nxt;
  logic [2:0]       w_ack_nxt;
  logic [15:0]      w_dig_nxt;

  logic             w_found;
  logic [1:0]       w_win;
  logic [1:0]       w_idx;
  logic [15:0]      w_win_data;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Scan starting at the round-robin pointer; the first asserted request wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    w_idx   = r_rr_ptr;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
      w_idx = wrap_inc(w_idx);
    end
  end

  always_comb begin
    case (w_win)
      2'd0:    w_win_data = bus.data0;
      2'd1:    w_win_data = bus.data1;
      default: w_win_data = bus.data2;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_owner;
    w_grant_nxt = r_grant;
    w_ack_nxt   = '0;
    w_dig_nxt   = r_dig;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        w_dig_nxt   = IDLE_DIGS;
        if (w_found) begin
          w_state_nxt = S_HOLD;
          w_grant_nxt = 3'(3'b001 << w_win);
          w_dig_nxt   = w_win_data;
          w_cnt_nxt   = '0;
          w_owner_nxt = w_win;
        end
      end
      S_HOLD: begin
        // Withdraw is checked first so it overrides the dwell end.
        if (!bus.req[r_owner]) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_dig_nxt   = IDLE_DIGS;
          w_rr_nxt    = wrap_inc(r_owner);
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_ACK;
          w_grant_nxt = '0;
          w_ack_nxt   = 3'(3'b001 << r_owner);
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_dig_nxt   = IDLE_DIGS;
        w_rr_nxt    = wrap_inc(r_owner);
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_dig_nxt   = IDLE_DIGS;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_grant  <= '0;
      r_ack    <= '0;
      r_busy   <= 1'b0;
      r_dig    <= IDLE_DIGS;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_owner  <= w_owner_nxt;
      r_grant  <= w_grant_nxt;
      r_ack    <= w_ack_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_dig    <= w_dig_nxt;
    end
  end

  assign bus.grant = r_grant;
  assign bus.ack   = r_ack;
  assign bus.busy  = r_busy;
  assign bus.dig_a = r_dig[15:12];
  assign bus.dig_b = r_dig[11:8];
  assign bus.dig_c = r_dig[7:4];
  assign bus.dig_d = r_dig[3:0];

endmodule
